// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch (I) and load/store (D)
// with round-robin arbitration, one access in flight, and a fixed memory latency.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MemLatency = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      IReq_i,
    input  logic [ADDR_WIDTH-1:0]     IAddr_i,
    output logic                      IGnt_o,
    output logic                      IRvalid_o,
    output logic [DATA_WIDTH-1:0]     IRdata_o,
    input  logic                      DReq_i,
    input  logic                      DWe_i,
    input  logic [ADDR_WIDTH-1:0]     DAddr_i,
    input  logic [DATA_WIDTH-1:0]     DWdata_i,
    input  logic [DATA_WIDTH/8-1:0]   DBe_i,
    output logic                      DGnt_o,
    output logic                      DRvalid_o,
    output logic [DATA_WIDTH-1:0]     DRdata_o,
    output logic                      MemReq_o,
    output logic                      MemWe_o,
    output logic [ADDR_WIDTH-1:0]     MemAddr_o,
    output logic [DATA_WIDTH-1:0]     MemWdata_o,
    output logic [DATA_WIDTH/8-1:0]   MemBe_o,
    input  logic [DATA_WIDTH-1:0]     MemRdata_i
);

    localparam logic [3:0] LAT_M1 = 4'(MemLatency - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                    r_state;
    logic [3:0]                r_cnt;
    logic                      r_prio_d;
    logic                      r_own_d;
    logic                      r_we;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_be;
    logic                      r_memreq;
    logic                      r_irvalid;
    logic                      r_drvalid;
    logic [DATA_WIDTH-1:0]     r_irdata;
    logic [DATA_WIDTH-1:0]     r_drdata;

    logic                      w_idle;
    logic                      w_both;
    logic                      w_gnt_i;
    logic                      w_gnt_d;

    // Combinational arbitration; grants are suppressed while reset is asserted
    always_comb begin
        w_idle  = (r_state == S_IDLE) && !rst_i;
        w_both  = IReq_i && DReq_i;
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (w_idle && w_both) begin
            w_gnt_d = r_prio_d;
            w_gnt_i = !r_prio_d;
        end else begin
            w_gnt_d = w_idle && DReq_i;
            w_gnt_i = w_idle && IReq_i;
        end
    end

    // Access sequencer: capture winner, strobe memory, count latency, return data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_prio_d  <= 1'b1;
            r_own_d   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_memreq  <= 1'b0;
            r_irvalid <= 1'b0;
            r_drvalid <= 1'b0;
            r_irdata  <= '0;
            r_drdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_irvalid <= 1'b0;
                    r_drvalid <= 1'b0;
                    if (w_gnt_i || w_gnt_d) begin
                        r_own_d  <= w_gnt_d;
                        r_addr   <= w_gnt_d ? DAddr_i : IAddr_i;
                        r_we     <= w_gnt_d && DWe_i;
                        r_wdata  <= w_gnt_d ? DWdata_i : '0;
                        r_be     <= w_gnt_d ? DBe_i : '1;
                        r_memreq <= 1'b1;
                        r_state  <= S_ISSUE;
                        if (w_both) begin
                            r_prio_d <= !r_prio_d;
                        end
                    end
                end
                S_ISSUE: begin
                    r_memreq <= 1'b0;
                    r_cnt    <= LAT_M1;
                    if (LAT_M1 == 4'd0) begin
                        r_state   <= S_RESP;
                        r_irvalid <= !r_own_d;
                        r_drvalid <= r_own_d;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state   <= S_RESP;
                        r_irvalid <= !r_own_d;
                        r_drvalid <= r_own_d;
                    end
                end
                S_RESP: begin
                    r_irvalid <= 1'b0;
                    r_drvalid <= 1'b0;
                    if (r_own_d) begin
                        r_drdata <= r_we ? '0 : MemRdata_i;
                    end else begin
                        r_irdata <= MemRdata_i;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read data is live from memory during the response cycle, then held
    always_comb begin
        IRdata_o = r_irvalid ? MemRdata_i : r_irdata;
        if (r_drvalid) begin
            DRdata_o = r_we ? '0 : MemRdata_i;
        end else begin
            DRdata_o = r_drdata;
        end
    end

    assign IGnt_o     = w_gnt_i;
    assign DGnt_o     = w_gnt_d;
    assign IRvalid_o  = r_irvalid;
    assign DRvalid_o  = r_drvalid;
    assign MemReq_o   = r_memreq;
    assign MemWe_o    = r_we;
    assign MemAddr_o  = r_addr;
    assign MemWdata_o = r_wdata;
    assign MemBe_o    = r_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with latency 1, one with latency 3.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;

    logic        a_ignt, a_irvalid, a_dgnt, a_drvalid, a_memreq, a_memwe;
    logic [31:0] a_irdata, a_drdata, a_memaddr, a_memwdata, a_mrdata;
    logic [3:0]  a_membe;
    logic        b_ignt, b_irvalid, b_dgnt, b_drvalid, b_memreq, b_memwe;
    logic [31:0] b_irdata, b_drdata, b_memaddr, b_memwdata, b_mrdata;
    logic [3:0]  b_membe;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MemLatency(1)) u_a (
        .clk_i(clk), .rst_i(rst),
        .IReq_i(ireq), .IAddr_i(iaddr), .IGnt_o(a_ignt), .IRvalid_o(a_irvalid), .IRdata_o(a_irdata),
        .DReq_i(dreq), .DWe_i(dwe), .DAddr_i(daddr), .DWdata_i(dwdata), .DBe_i(dbe),
        .DGnt_o(a_dgnt), .DRvalid_o(a_drvalid), .DRdata_o(a_drdata),
        .MemReq_o(a_memreq), .MemWe_o(a_memwe), .MemAddr_o(a_memaddr), .MemWdata_o(a_memwdata),
        .MemBe_o(a_membe), .MemRdata_i(a_mrdata)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MemLatency(3)) u_b (
        .clk_i(clk), .rst_i(rst),
        .IReq_i(ireq), .IAddr_i(iaddr), .IGnt_o(b_ignt), .IRvalid_o(b_irvalid), .IRdata_o(b_irdata),
        .DReq_i(dreq), .DWe_i(dwe), .DAddr_i(daddr), .DWdata_i(dwdata), .DBe_i(dbe),
        .DGnt_o(b_dgnt), .DRvalid_o(b_drvalid), .DRdata_o(b_drdata),
        .MemReq_o(b_memreq), .MemWe_o(b_memwe), .MemAddr_o(b_memaddr), .MemWdata_o(b_memwdata),
        .MemBe_o(b_membe), .MemRdata_i(b_mrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ireq   = 1'b0;
        iaddr  = 32'h0;
        dreq   = 1'b0;
        dwe    = 1'b0;
        daddr  = 32'h0;
        dwdata = 32'h0;
        dbe    = 4'h0;
        nxt();
        nxt();
    endtask

    initial begin
        a_mrdata = 32'h0;
        b_mrdata = 32'h0;

        // Reset state
        do_reset();
        #1;
        chk("rst_ignt", a_ignt, 1'b0);
        chk("rst_dgnt", a_dgnt, 1'b0);
        chk("rst_memreq", a_memreq, 1'b0);
        chk("rst_memaddr", a_memaddr, 32'h0);
        chk("rst_membe", a_membe, 4'h0);
        chk("rst_irdata", a_irdata, 32'h0);
        chk("rst_drvalid", a_drvalid, 1'b0);

        // Test 1: single fetch, latency 1
        nxt(); rst = 1'b0; ireq = 1'b1; iaddr = 32'h0000_0010; #1;
        chk("t1_ignt", a_ignt, 1'b1);
        chk("t1_dgnt", a_dgnt, 1'b0);
        nxt(); ireq = 1'b0; #1;
        chk("t1_memreq", a_memreq, 1'b1);
        chk("t1_memaddr", a_memaddr, 32'h10);
        chk("t1_memwe", a_memwe, 1'b0);
        chk("t1_membe", a_membe, 4'hF);
        chk("t1_ignt_issue", a_ignt, 1'b0);
        nxt(); a_mrdata = 32'h0A0B_0C0D; #1;
        chk("t1_irvalid", a_irvalid, 1'b1);
        chk("t1_irdata", a_irdata, 32'h0A0B_0C0D);
        chk("t1_drvalid", a_drvalid, 1'b0);
        nxt(); a_mrdata = 32'h1111_1111; #1;
        chk("t1_irvalid_end", a_irvalid, 1'b0);
        chk("t1_irdata_hold", a_irdata, 32'h0A0B_0C0D);
        chk("t1_memreq_end", a_memreq, 1'b0);

        // Test 2: both requesters held, round-robin D, I, D, I
        do_reset();
        for (int c = 0; c < 12; c++) begin
            nxt();
            rst = 1'b0; ireq = 1'b1; dreq = 1'b1; iaddr = 32'h100; daddr = 32'h200; dwe = 1'b0;
            #1;
            chk("t2_dgnt", a_dgnt, (c == 0 || c == 6) ? 1'b1 : 1'b0);
            chk("t2_ignt", a_ignt, (c == 3 || c == 9) ? 1'b1 : 1'b0);
            chk("t2_drvalid", a_drvalid, (c == 2 || c == 8) ? 1'b1 : 1'b0);
            chk("t2_irvalid", a_irvalid, (c == 5 || c == 11) ? 1'b1 : 1'b0);
            if (c == 1 || c == 7) chk("t2_addr_d", a_memaddr, 32'h200);
            if (c == 4 || c == 10) chk("t2_addr_i", a_memaddr, 32'h100);
        end

        // Test 3: store
        do_reset();
        nxt(); rst = 1'b0; dreq = 1'b1; dwe = 1'b1; daddr = 32'h104; dwdata = 32'hDEAD_BEEF; dbe = 4'h3; #1;
        chk("t3_dgnt", a_dgnt, 1'b1);
        nxt(); dreq = 1'b0; #1;
        chk("t3_memreq", a_memreq, 1'b1);
        chk("t3_memwe", a_memwe, 1'b1);
        chk("t3_membe", a_membe, 4'h3);
        chk("t3_memaddr", a_memaddr, 32'h104);
        chk("t3_memwdata", a_memwdata, 32'hDEAD_BEEF);
        nxt(); a_mrdata = 32'hFFFF_FFFF; #1;
        chk("t3_drvalid", a_drvalid, 1'b1);
        chk("t3_drdata", a_drdata, 32'h0);
        chk("t3_irvalid", a_irvalid, 1'b0);
        nxt(); #1;
        chk("t3_drvalid_end", a_drvalid, 1'b0);
        chk("t3_memreq_end", a_memreq, 1'b0);

        // Test 6: fetch then load, each side holds its own data
        do_reset();
        nxt(); rst = 1'b0; dwe = 1'b0; ireq = 1'b1; iaddr = 32'h20; #1;
        chk("t6_ignt", a_ignt, 1'b1);
        nxt(); ireq = 1'b0; #1;
        nxt(); a_mrdata = 32'h0050_0093; #1;
        chk("t6_irvalid", a_irvalid, 1'b1);
        chk("t6_irdata", a_irdata, 32'h0050_0093);
        nxt(); a_mrdata = 32'h0; dreq = 1'b1; daddr = 32'h300; #1;
        chk("t6_dgnt", a_dgnt, 1'b1);
        nxt(); dreq = 1'b0; #1;
        nxt(); a_mrdata = 32'h1234_5678; #1;
        chk("t6_drvalid", a_drvalid, 1'b1);
        chk("t6_drdata", a_drdata, 32'h1234_5678);
        chk("t6_irdata_keep", a_irdata, 32'h0050_0093);
        nxt(); a_mrdata = 32'h0; #1;
        chk("t6_drdata_hold", a_drdata, 32'h1234_5678);
        chk("t6_irdata_hold", a_irdata, 32'h0050_0093);

        // Test 4: latency 3 fetch, DReq held after the grant
        do_reset();
        nxt(); rst = 1'b0; ireq = 1'b1; iaddr = 32'h40; #1;
        chk("t4_ignt", b_ignt, 1'b1);
        nxt(); ireq = 1'b0; dreq = 1'b1; dwe = 1'b0; daddr = 32'h80; #1;
        chk("t4_memreq", b_memreq, 1'b1);
        chk("t4_memaddr", b_memaddr, 32'h40);
        chk("t4_dgnt_c1", b_dgnt, 1'b0);
        for (int c = 2; c < 4; c++) begin
            nxt(); #1;
            chk("t4_dgnt_wait", b_dgnt, 1'b0);
            chk("t4_ignt_wait", b_ignt, 1'b0);
            chk("t4_irvalid_wait", b_irvalid, 1'b0);
            chk("t4_memreq_wait", b_memreq, 1'b0);
        end
        nxt(); b_mrdata = 32'hCAFE_F00D; #1;
        chk("t4_irvalid", b_irvalid, 1'b1);
        chk("t4_irdata", b_irdata, 32'hCAFE_F00D);
        chk("t4_dgnt_resp", b_dgnt, 1'b0);
        nxt(); b_mrdata = 32'h0; #1;
        chk("t4_dgnt_idle", b_dgnt, 1'b1);

        // Test 5: reset during WAIT abandons the load
        nxt(); #1;
        chk("t5_memreq", b_memreq, 1'b1);
        nxt(); rst = 1'b1; #1;
        nxt(); #1;
        chk("t5_rst_dgnt", b_dgnt, 1'b0);
        chk("t5_rst_drvalid", b_drvalid, 1'b0);
        chk("t5_rst_memreq", b_memreq, 1'b0);
        chk("t5_rst_memaddr", b_memaddr, 32'h0);
        chk("t5_rst_membe", b_membe, 4'h0);
        chk("t5_rst_irdata", b_irdata, 32'h0);
        nxt(); rst = 1'b0; #1;
        chk("t5_dgnt_after", b_dgnt, 1'b1);
        chk("t5_no_stale_rvalid", b_drvalid, 1'b0);
        nxt(); dreq = 1'b0; #1;
        chk("t5_memaddr", b_memaddr, 32'h80);
        nxt(); #1;
        chk("t5_drvalid_wait", b_drvalid, 1'b0);
        nxt(); #1;
        nxt(); b_mrdata = 32'h5A5A_A5A5; #1;
        chk("t5_drvalid", b_drvalid, 1'b1);
        chk("t5_drdata", b_drdata, 32'h5A5A_A5A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares a single synchronous memory port between two requesters of the multicycle core: instruction fetch (I) and load/store (D).
- Arbitrates with round-robin priority and issues one access at a time.
- Waits a configurable fixed memory latency, then returns read data to the requester that won.
- Sits between the core's fetch/LSU logic and the unified program/data memory.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; byte-enable width is DATA_WIDTH/8.
- MemLatency, 1, cycles from MemReq_o accepted to MemRdata_i valid; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- IReq_i  in  1  fetch request.
- IAddr_i  in  ADDR_WIDTH  fetch byte address.
- IGnt_o  out  1  fetch request accepted this cycle.
- IRvalid_o  out  1  IRdata_o valid, one-cycle pulse.
- IRdata_o  out  DATA_WIDTH  fetched instruction.
- DReq_i  in  1  data request.
- DWe_i  in  1  1 = store, 0 = load.
- DAddr_i  in  ADDR_WIDTH  data byte address.
- DWdata_i  in  DATA_WIDTH  store data.
- DBe_i  in  DATA_WIDTH/8  store byte enables.
- DGnt_o  out  1  data request accepted this cycle.
- DRvalid_o  out  1  load data valid or store complete, one-cycle pulse.
- DRdata_o  out  DATA_WIDTH  load data; 0 for stores.
- MemReq_o  out  1  memory access strobe, one cycle.
- MemWe_o  out  1  memory write.
- MemAddr_o  out  ADDR_WIDTH  memory byte address.
- MemWdata_o  out  DATA_WIDTH  memory write data.
- MemBe_o  out  DATA_WIDTH/8  memory byte enables.
- MemRdata_i  in  DATA_WIDTH  memory read data, valid MemLatency cycles after MemReq_o.

Behaviour:
- **Clock and reset.** One clock, clk_i. Reset is synchronous, active-high on rst_i.
- **Reset values.**
  - State = IDLE, latency counter = 0, priority pointer = D.
  - All *_o outputs = 0.
  - Reset mid-access abandons the transaction: no Rvalid pulse is issued for it.
- **FSM states.** IDLE, ISSUE, WAIT, RESP.
- **IDLE.**
  - Arbitration is combinational on IReq_i/DReq_i.
  - Only one requested: that one wins.
  - Both requested: the side named by the priority pointer wins, and the pointer flips to the other side.
  - Single-requester wins leave the pointer unchanged.
  - Winner's Gnt_o is asserted combinationally in the same cycle.
  - Winner's address, data, BE, WE and an owner flag are registered. Next state = ISSUE.
- **Grant rules.**
  - Gnt is asserted only in IDLE. I and D grants are never both high.
  - For fetches, MemWe_o = 0 and MemBe_o = all ones.
- **ISSUE.**
  - MemReq_o = 1 for exactly one cycle, driven from the registered fields.
  - Counter loads MemLatency-1.
  - Next state = RESP if MemLatency = 1, else WAIT.
- **WAIT.** Counter decrements each cycle. At counter = 1, next state = RESP.
- **RESP.**
  - Owner's Rvalid_o = 1 for one cycle.
  - Rdata_o = MemRdata_i, except stores, where DRdata_o = 0.
  - Non-owner Rvalid_o = 0. Next state = IDLE.
- **Rdata holding.**
  - IRdata_o/DRdata_o are registered and hold their last value until the next Rvalid for that side.
  - This lets the multicycle datapath sample late.
- **Throughput.** One access per MemLatency+2 cycles. A grant in cycle t produces Rvalid in cycle t+1+MemLatency.
- **Requester obligations.**
  - Keep Req and payload stable until Gnt.
  - Requests deasserted before grant are simply dropped. There is no error.
  - A request held through RESP is eligible in the next IDLE cycle.
- **Addresses.**
  - Addresses pass through unmodified. Word alignment is the memory's concern.
  - Misaligned addresses are not trapped here.
- **Outputs outside RESP.** Mem* outputs other than MemReq_o hold the registered values. Mem* outputs are 0 only after reset.

Test Plan:
1. Reset, then IReq_i = 1 with IAddr_i = 0x0000_0010, MemLatency = 1 → IGnt_o in cycle 0; MemReq_o/MemAddr_o = 0x10 in cycle 1; IRvalid_o with IRdata_o = MemRdata_i in cycle 2.
2. After reset, IReq_i and DReq_i both asserted, held continuously → grants in order D, I, D, I. No overlapping grants. Each Rvalid goes only to the owner.
3. Store: DWe_i = 1, DAddr_i = 0x104, DWdata_i = 0xDEADBEEF, DBe_i = 0x3 → MemWe_o = 1 and MemBe_o = 0x3 for one cycle; DRvalid_o pulse with DRdata_o = 0.
4. MemLatency = 3, single fetch → IRvalid_o exactly 4 cycles after IGnt_o. IGnt_o and DGnt_o stay low throughout, even with DReq_i held.
5. Assert rst_i during WAIT → next cycle state IDLE, all outputs 0, no Rvalid for the aborted access. A held DReq_i is granted in the first IDLE cycle after reset releases.
6. Fetch 0x20 returns 0x00500093, then a load returns 0x12345678 → IRdata_o still reads 0x00500093 while DRdata_o updates.
